// File: rtl/plab5_mcore_debug_issuer.sv
// Host-side debug request issuer: queues host commands, pulses them one at a time to the
// debug checker and returns the acked data. WAIT timeout enabled by PLAB5_MCORE_DEBUG_ISSUER_TIMEOUT_EN.
module plab5_mcore_debug_issuer #(
    parameter int unsigned p_addr_nbits     = 32,
    parameter int unsigned p_data_nbits     = 32,
    parameter int unsigned p_num_entries    = 4,
    parameter int unsigned p_timeout_cycles = 64
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    host_req_val,
    output logic                    host_req_rdy,
    input  logic                    host_req_domain,
    input  logic [p_addr_nbits-1:0] host_req_src_addr,
    input  logic [p_addr_nbits-1:0] host_req_dest_addr,
    input  logic                    host_req_inst,

    output logic                    host_resp_val,
    input  logic                    host_resp_rdy,
    output logic [p_data_nbits-1:0] host_resp_data,
    output logic                    host_resp_status,

    output logic                    debug_val,
    output logic                    debug_domain,
    output logic [p_addr_nbits-1:0] debug_src_addr,
    output logic [p_addr_nbits-1:0] debug_dest_addr,
    output logic                    debug_inst,
    input  logic                    debug_ack,
    input  logic [p_data_nbits-1:0] debug_data
);

    localparam int unsigned PtrW = $clog2(p_num_entries);
    localparam int unsigned CntW = PtrW + 1;

    if ((p_num_entries < 2) || ((p_num_entries & (p_num_entries - 1)) != 0) ||
        (p_timeout_cycles < 2)) begin : g_bad_params
        $error("plab5_mcore_debug_issuer: invalid parameter values");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    typedef struct packed {
        logic                    domain;
        logic [p_addr_nbits-1:0] src;
        logic [p_addr_nbits-1:0] dest;
        logic                    inst;
    } entry_t;

    state_e                  state_q, state_d;
    entry_t                  mem_q [p_num_entries];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [p_data_nbits-1:0] resp_data_q, resp_data_d;
    logic                    push, pop, timeout;
    entry_t                  head;

`ifdef PLAB5_MCORE_DEBUG_ISSUER_TIMEOUT_EN
    localparam int unsigned TmrRaw = $clog2(p_timeout_cycles) + 1;
    localparam int unsigned TmrW   = (TmrRaw < 8) ? 8 : TmrRaw;

    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            resp_status_q, resp_status_d;

    // An ack arriving on the final WAIT cycle takes priority over the timeout.
    assign timeout = (state_q == StWait) && !debug_ack &&
                     (tmr_q == TmrW'(p_timeout_cycles - 1));

    always_comb begin
        tmr_d         = tmr_q;
        resp_status_d = resp_status_q;
        if (state_q == StIssue) begin
            tmr_d = '0;
        end else if (state_q == StWait) begin
            tmr_d = tmr_q + TmrW'(1);
            if (debug_ack) begin
                resp_status_d = 1'b0;
            end else if (timeout) begin
                resp_status_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q         <= '0;
            resp_status_q <= 1'b0;
        end else begin
            tmr_q         <= tmr_d;
            resp_status_q <= resp_status_d;
        end
    end

    assign host_resp_status = resp_status_q;
`else
    assign timeout          = 1'b0;
    assign host_resp_status = 1'b0;
`endif

    assign host_req_rdy   = (count_q != CntW'(p_num_entries));
    assign push           = host_req_val && host_req_rdy;
    assign pop            = (state_q == StWait) && (debug_ack || timeout);
    assign head           = mem_q[rd_ptr_q];
    assign host_resp_data = resp_data_q;

    // FIFO bookkeeping and response capture
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        resp_data_d = resp_data_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (state_q == StWait) begin
            if (debug_ack) begin
                resp_data_d = debug_data;
            end else if (timeout) begin
                resp_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{domain: host_req_domain, src: host_req_src_addr,
                                 dest: host_req_dest_addr, inst: host_req_inst};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            resp_data_q <= resp_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (debug_ack || timeout) state_d = StResp;
            StResp:  if (host_resp_rdy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        host_resp_val   = (state_q == StResp);
        debug_val       = 1'b0;
        debug_domain    = 1'b0;
        debug_src_addr  = '0;
        debug_dest_addr = '0;
        debug_inst      = 1'b0;
        if (state_q == StIssue) begin
            debug_val       = 1'b1;
            debug_domain    = head.domain;
            debug_src_addr  = head.src;
            debug_dest_addr = head.dest;
            debug_inst      = head.inst;
        end
    end

endmodule
